// File: rtl/config_packet_generator.sv
// Expands one host configuration command into a stream of configuration packets
// for the NI FIFO. It emits one packet per neuron, or one per (neuron, axon) pair for synaptic codes.
module config_packet_generator #(
  parameter int NURN_CNT_BIT_WIDTH   = 8,
  parameter int AXON_CNT_BIT_WIDTH   = 8,
  parameter int DSIZE                = 16,
  parameter int PARAMETER_SELECT_BIT = 4,
  parameter int PACKET_SIZE          = PARAMETER_SELECT_BIT + NURN_CNT_BIT_WIDTH + DSIZE + DSIZE
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            start_i,
  input  logic [PARAMETER_SELECT_BIT-1:0] param_code_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]   neuron_first_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]   neuron_last_i,
  input  logic [AXON_CNT_BIT_WIDTH-1:0]   axon_first_i,
  input  logic [AXON_CNT_BIT_WIDTH-1:0]   axon_last_i,
  input  logic [2*DSIZE-1:0]              data_i,
  input  logic                            NI_full,
  output logic                            write_NI,
  output logic [PACKET_SIZE-1:0]          packet_out,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o
);

  localparam int PAD_W = DSIZE - AXON_CNT_BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic [PARAMETER_SELECT_BIT-1:0] code_r;
  logic [NURN_CNT_BIT_WIDTH-1:0]   nl_r, ncnt_r;
  logic [AXON_CNT_BIT_WIDTH-1:0]   af_r, al_r, acnt_r;
  logic [2*DSIZE-1:0]              data_r;
  logic                            error_r;
  logic                            reject_s;
  logic                            last_s;
  logic                            push_s;

  // Codes 13..15 address synapses (post-history, pre-history, weight).
  function automatic logic is_synaptic(input logic [PARAMETER_SELECT_BIT-1:0] code);
    return (code == PARAMETER_SELECT_BIT'(13)) ||
           (code == PARAMETER_SELECT_BIT'(14)) ||
           (code == PARAMETER_SELECT_BIT'(15));
  endfunction

  // Command legality check on the raw inputs seen at the start strobe
  always_comb begin
    reject_s = (param_code_i == PARAMETER_SELECT_BIT'(9)) ||
               (neuron_first_i > neuron_last_i) ||
               (is_synaptic(param_code_i) && (axon_first_i > axon_last_i));
  end

  // Final-target detection uses equality before increment so a range ending at the max id never wraps
  always_comb begin
    if (is_synaptic(code_r)) begin
      last_s = (ncnt_r == nl_r) && (acnt_r == al_r);
    end else begin
      last_s = (ncnt_r == nl_r);
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    write_NI     = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i && !reject_s) begin
          state_next_s = EMIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      EMIT: begin
        busy_o   = 1'b1;
        push_s   = !NI_full;
        write_NI = push_s;
        if (push_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = EMIT;
        end
      end
      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Command capture in IDLE and target-counter advance on each FIFO push
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      code_r  <= '0;
      nl_r    <= '0;
      ncnt_r  <= '0;
      af_r    <= '0;
      al_r    <= '0;
      acnt_r  <= '0;
      data_r  <= '0;
      error_r <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            code_r  <= param_code_i;
            nl_r    <= neuron_last_i;
            ncnt_r  <= neuron_first_i;
            af_r    <= axon_first_i;
            al_r    <= axon_last_i;
            acnt_r  <= axon_first_i;
            data_r  <= data_i;
            error_r <= reject_s;
          end
        end
        EMIT: begin
          if (push_s && !last_s) begin
            if (is_synaptic(code_r)) begin
              if (acnt_r == al_r) begin
                acnt_r <= af_r;
                ncnt_r <= ncnt_r + NURN_CNT_BIT_WIDTH'(1);
              end else begin
                acnt_r <= acnt_r + AXON_CNT_BIT_WIDTH'(1);
              end
            end else begin
              ncnt_r <= ncnt_r + NURN_CNT_BIT_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign error_o = error_r;

  // Packet assembly from the captured command and live counters
  always_comb begin
    if (is_synaptic(code_r)) begin
      packet_out = {code_r, ncnt_r, acnt_r, {PAD_W{1'b0}}, data_r[DSIZE-1:0]};
    end else begin
      packet_out = {code_r, ncnt_r, data_r};
    end
  end

endmodule

// File: tb/tb_config_packet_generator.sv
// Bench for config_packet_generator: a queue of expected packets built from the
// command ranges, with randomized commands, backpressure and reset-abort scenarios.
module tb_config_packet_generator;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  code;
  logic [7:0]  nf, nl, af, al;
  logic [31:0] data;
  logic        ni_full;
  logic        write_ni;
  logic [43:0] packet_out;
  logic        busy, done, error;

  config_packet_generator dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .param_code_i(code),
    .neuron_first_i(nf), .neuron_last_i(nl), .axon_first_i(af), .axon_last_i(al),
    .data_i(data), .NI_full(ni_full), .write_NI(write_ni), .packet_out(packet_out),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [43:0] exp_q[$];
  logic [43:0] wr_log[$];
  bit          bp_pat[$];
  bit          exp_done = 1'b0;
  bit          exp_err  = 1'b0;
  int          cmd_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [43:0] model_pkt(input int c, input int n, input int a, input logic [31:0] d);
    logic [3:0] c4;
    logic [7:0] n8;
    logic [7:0] a8;
    c4 = c[3:0];
    n8 = n[7:0];
    a8 = a[7:0];
    if (c >= 13) return {c4, n8, a8, 8'h00, d[15:0]};
    return {c4, n8, d};
  endfunction

  function automatic bit next_full(input int pct);
    if (bp_pat.size() > 0) return bp_pat.pop_front();
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic scramble();
    code = 4'($urandom_range(0, 15));
    nf   = 8'($urandom_range(0, 255));
    nl   = 8'($urandom_range(0, 255));
    af   = 8'($urandom_range(0, 255));
    al   = 8'($urandom_range(0, 255));
    data = $urandom;
  endtask

  // Per-cycle comparison of every DUT output against the expected-packet queue
  always @(negedge clk) begin
    logic [43:0] tmp;
    bit nxt_done;
    if (!reset_n) begin
      exp_q.delete();
      exp_done = 1'b0;
      chk("rst_write", write_ni, 0);
      chk("rst_packet", packet_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
    end else begin
      chk("done", done, exp_done);
      chk("busy", busy, (exp_q.size() > 0) || exp_done);
      chk("error", error, exp_err);
      chk("write", write_ni, (exp_q.size() > 0) && !ni_full);
      if (exp_q.size() > 0) chk("packet", packet_out, exp_q[0]);
      nxt_done = 1'b0;
      if (write_ni) begin
        wr_log.push_back(packet_out);
        cmd_writes++;
        if (exp_q.size() > 0) begin
          tmp = exp_q.pop_front();
          if (exp_q.size() == 0) nxt_done = 1'b1;
        end
      end
      exp_done = nxt_done;
    end
  end

  task automatic run_cmd(input int c, input int f, input int l, input int a0, input int a1,
                         input logic [31:0] d, input int pct, input bit noise);
    bit rej;
    int exp_n;
    int cyc;
    rej = (c == 9) || (f > l) || ((c >= 13) && (a0 > a1));
    code = c[3:0]; nf = f[7:0]; nl = l[7:0]; af = a0[7:0]; al = a1[7:0]; data = d;
    start = 1'b1;
    ni_full = next_full(pct);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    ni_full = next_full(pct);
    if (rej) begin
      exp_err = 1'b1;
      @(posedge clk); #1;
      exp_err = 1'b0;
    end else begin
      exp_n = (l - f + 1) * ((c >= 13) ? (a1 - a0 + 1) : 1);
      cmd_writes = 0;
      wr_log.delete();
      for (int n = f; n <= l; n++) begin
        if (c >= 13) begin
          for (int a = a0; a <= a1; a++) exp_q.push_back(model_pkt(c, n, a, d));
        end else begin
          exp_q.push_back(model_pkt(c, n, 0, d));
        end
      end
      cyc = 0;
      while ((exp_q.size() > 0 || exp_done) && cyc < 5000) begin
        @(posedge clk); #1;
        cyc++;
        ni_full = next_full(pct);
        start = noise ? (($urandom_range(0, 1) == 1) || exp_done) : 1'b0;
        scramble();
      end
      start = 1'b0;
      if (cyc >= 5000) begin
        errors++;
        checks++;
        $display("FAIL timeout: command code %0d still active after %0d cycles", c, cyc);
      end
      chk("count", cmd_writes, exp_n);
    end
  endtask

  initial begin
    int cyc;
    int c, f, l, a0, a1;
    reset_n = 1'b0;
    start = 1'b0; code = '0; nf = '0; nl = '0; af = '0; al = '0; data = '0; ni_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // per-neuron basic
    run_cmd(6, 3, 5, 0, 0, 32'h0000_1234, 0, 1'b0);
    chk("pn_pkt0", wr_log[0], 44'h603_0000_1234);
    chk("pn_pkt2", wr_log[2], 44'h605_0000_1234);

    // synaptic with axon range at the top end
    run_cmd(15, 1, 2, 254, 255, 32'h5555_ABCD, 0, 1'b0);
    chk("syn_pkt0", wr_log[0], 44'hF01_FE00_ABCD);
    chk("syn_pkt1", wr_log[1], 44'hF01_FF00_ABCD);
    chk("syn_pkt3", wr_log[3], 44'hF02_FF00_ABCD);

    // backpressure pattern
    bp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    run_cmd(6, 3, 5, 0, 0, 32'h0000_1234, 0, 1'b0);
    chk("bp_pkt1", wr_log[1], 44'h604_0000_1234);

    // boundaries and rejections
    run_cmd(0, 255, 255, 0, 0, 32'hDEAD_BEEF, 30, 1'b0);
    chk("max_pkt", wr_log[0], 44'h0FF_DEAD_BEEF);
    run_cmd(9, 0, 3, 0, 0, 32'h1, 0, 1'b0);
    run_cmd(2, 5, 4, 0, 0, 32'h2, 0, 1'b0);
    run_cmd(14, 1, 1, 9, 8, 32'h3, 0, 1'b0);

    // start noise during EMIT and DONE
    run_cmd(3, 10, 15, 0, 0, $urandom, 20, 1'b1);
    run_cmd(13, 0, 1, 0, 2, $urandom, 20, 1'b1);

    // reset after 2 of 10 packets
    code = 4'd2; nf = 8'd0; nl = 8'd9; af = 8'd0; al = 8'd0; data = 32'hCAFE_0001;
    start = 1'b1; ni_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_writes = 0;
    for (int n = 0; n <= 9; n++) exp_q.push_back(model_pkt(2, n, 0, 32'hCAFE_0001));
    cyc = 0;
    while (cmd_writes < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    reset_n = 1'b0;
    #1;
    chk("rst_now_write", write_ni, 0);
    chk("rst_now_busy", busy, 0);
    @(posedge clk); #1;
    chk("rst_abort_count", cmd_writes, 2);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(2, 0, 9, 0, 0, 32'hCAFE_0002, 10, 1'b0);
    chk("post_rst_pkt0", wr_log[0], 44'h200_CAFE_0002);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      c  = $urandom_range(0, 15);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255);
      l  = f + $urandom_range(0, 3);
      if (l > 255) l = 255;
      if ($urandom_range(0, 9) == 0 && f > 0) l = f - 1;
      a0 = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255);
      a1 = a0 + $urandom_range(0, 3);
      if (a1 > 255) a1 = 255;
      if ($urandom_range(0, 9) == 0 && a0 > 0) a1 = a0 - 1;
      run_cmd(c, f, l, a0, a1, $urandom, $urandom_range(0, 50), $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_packet_generator.md
# config_packet_generator

Transmit-side counterpart of the neuron configuration decoder. It turns a single host configuration command into a stream of configuration packets and pushes them into the network-interface (NI) FIFO. A command names a parameter code, a neuron range and an axon range, and the block emits one packet per target. Packets use exactly the format the neuron-side memory controller decodes.

## Interface
Parameters:
- NURN_CNT_BIT_WIDTH, 8, neuron id width
- AXON_CNT_BIT_WIDTH, 8, axon id width
- DSIZE, 16, data word width
- PARAMETER_SELECT_BIT, 4, parameter code width
- PACKET_SIZE, PARAMETER_SELECT_BIT+NURN_CNT_BIT_WIDTH+DSIZE+DSIZE, packet width (44)

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  command strobe; sampled only in IDLE
- param_code_i  in  PARAMETER_SELECT_BIT  parameter code (0–8, 10–15 valid; 9 reserved)
- neuron_first_i / neuron_last_i  in  NURN_CNT_BIT_WIDTH  inclusive neuron range
- axon_first_i / axon_last_i  in  AXON_CNT_BIT_WIDTH  inclusive axon range (synaptic codes only)
- data_i  in  2*DSIZE  parameter payload
- NI_full  in  1  NI FIFO full
- write_NI  out  1  FIFO push strobe
- packet_out  out  PACKET_SIZE  packet presented with write_NI
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle pulse, command finished
- error_o  out  1  one-cycle pulse, command rejected

## Operation
- States: IDLE, EMIT, DONE.
- **IDLE.** On start_i=1, capture all command inputs into registers. Neuron counter := neuron_first_i and axon counter := axon_first_i.
  - Reject the command if any of these hold: code==9; neuron_first>neuron_last; or, for a synaptic code, axon_first>axon_last. A rejected command pulses error_o the next cycle and the state stays IDLE.
  - Otherwise go to EMIT.
- Synaptic codes are 13, 14 and 15 (post-history, pre-history, weight). All other valid codes are per-neuron.
- Packet format:
  - Per-neuron: {code, neuron_cnt, data[2*DSIZE-1:0]}.
  - Synaptic: {code, neuron_cnt, axon_cnt, data[DSIZE-1:0]}. The axon id occupies bits [2*DSIZE-1:2*DSIZE-AXON_CNT_BIT_WIDTH]; the bits between the axon id and data[DSIZE-1:0] are zero.
- **EMIT.** write_NI = !NI_full, combinational. packet_out is formed from the registers. Each cycle with write_NI=1 advances the counters:
  - Synaptic codes: the axon counter is the inner loop. When axon_cnt==axon_last, set axon_cnt := axon_first and increment neuron_cnt.
  - Per-neuron codes: increment neuron_cnt.
  - The write of the final target (neuron_cnt==neuron_last and, for synaptic codes, axon_cnt==axon_last) moves the state to DONE.
- End-of-range detection is by equality compare before increment, so a range ending at 255 never wraps.
- Packet count: per-neuron codes emit (nl−nf+1) packets; synaptic codes emit (nl−nf+1)*(al−af+1).
- **DONE.** done_o=1 for exactly one cycle, then return to IDLE.
- busy_o=1 in EMIT and DONE.
- start_i is ignored outside IDLE, including in the DONE cycle.
- Command inputs may change freely after the capture cycle.

## Timing
- Reset values: state IDLE, write_NI=0, packet_out=0, busy_o=0, done_o=0, error_o=0, all counters 0.
- Reset mid-command aborts immediately. No further write_NI is issued, and any partial packet stream is not completed.
- start_i sampled high at edge 0 gives state EMIT and busy_o=1 from edge 0. The first write_NI can occur in the cycle after edge 0 (latency 1).
- Throughput is one packet per cycle while NI_full=0.
- NI_full=1 stalls with write_NI=0. Counters and packet_out hold.
- The FIFO captures packet_out at the rising edge where write_NI=1.
- The last write happens in cycle N. done_o=1 and busy_o=1 in cycle N+1. busy_o=0 in cycle N+2, when IDLE accepts a new start.
- error_o is pulsed the cycle after the rejected start_i edge; busy_o stays 0.

## Test plan
- Per-neuron command: code=6 (FixedThreshold), neurons 3..5, data=0x0000_1234, NI_full=0. Expect 3 consecutive write_NI with packets {6,3,0x00001234}, {6,4,…}, {6,5,…}, then done_o one cycle later.
- Synaptic command: code=15, neurons 1..2, axons 254..255, data[15:0]=0xABCD. Expect 4 packets in order (1,254), (1,255), (2,254), (2,255). Axon field sits in bits [31:24]; low 16 bits are 0xABCD.
- Backpressure: the same per-neuron command with NI_full toggling 1,1,0,1,0,0. Expect no write_NI while full, no duplicate or skipped ids, and packet_out stable during stalls.
- Boundary: neurons 255..255, code=0. Expect exactly 1 packet with no wrap. Also code=9, and neuron_first=5 with neuron_last=4. Each pulses error_o with zero writes and busy_o=0.
- start_i asserted during EMIT and during DONE is ignored; packet count is unchanged.
- Assert reset_n_i low after 2 of 10 packets. Expect write_NI=0 immediately and all outputs at reset values. A fresh start then emits from neuron_first_i.
